// File: rtl/bcd_to_bin_pkg.sv
// Shared types and constants for the BCD-to-binary converter.
// Reverse double-dabble: shift right, then subtract 3 from each digit >= 8.
package bcd_to_bin_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OP   = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] BCD_MAX    = 4'd9;
    localparam logic [3:0] ADJ_THRESH = 4'd8;
    localparam logic [3:0] ADJ_VAL    = 4'd3;

    // A digit is legal BCD when it does not exceed nine.
    function automatic logic digit_valid(input logic [3:0] d);
        return d <= BCD_MAX;
    endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// Per-digit correction step of the reverse double-dabble.
// Purely combinational; never borrows into a neighbouring digit.
module bcd_digit_adjust
    import bcd_to_bin_pkg::*;
(
    input  logic [3:0] digit,
    output logic [3:0] adjusted
);

    // Subtract three from any digit that reached eight after the shift.
    always_comb begin
        adjusted = digit;
        if (digit >= ADJ_THRESH) begin
            adjusted = digit - ADJ_VAL;
        end
    end

endmodule

// File: rtl/bcd_to_bin.sv
// Sequential BCD-to-binary converter (start/ready/done FSMD).
// One shift-and-correct iteration per clock, BIN_WIDTH iterations.
module bcd_to_bin
    import bcd_to_bin_pkg::*;
#(
    parameter int DIGITS    = 4,
    parameter int BIN_WIDTH = 14
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [3:0]           bcd_in [DIGITS],
    output logic                 ready,
    output logic                 done_tick,
    output logic                 err,
    output logic [BIN_WIDTH-1:0] bin_out
);

    localparam int BCD_W  = 4 * DIGITS;
    localparam int WORK_W = BCD_W + BIN_WIDTH;
    localparam int N_W    = $clog2(BIN_WIDTH + 1);

    state_t state_reg;
    state_t state_next;

    logic [WORK_W-1:0]    work_reg;
    logic [WORK_W-1:0]    work_next;
    logic [N_W-1:0]       n_reg;
    logic [N_W-1:0]       n_next;
    logic [BIN_WIDTH-1:0] bin_next;
    logic                 err_next;
    logic                 done_next;
    logic                 ready_next;

    logic [BCD_W-1:0]     bcd_packed;
    logic                 bad_digit;
    logic [WORK_W-1:0]    shifted;
    logic [BCD_W-1:0]     adj_digits;
    logic [WORK_W-1:0]    iter_result;
    logic                 last_iter;

    // Flatten the digit array (index 0 = units in the low nibble) and
    // flag any nibble that is not a legal decimal digit.
    always_comb begin
        bcd_packed = '0;
        bad_digit  = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            bcd_packed[4*i +: 4] = bcd_in[i];
            if (!digit_valid(bcd_in[i])) begin
                bad_digit = 1'b1;
            end
        end
    end

    assign shifted = work_reg >> 1;

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_adj
            bcd_digit_adjust u_adj (
                .digit    (shifted[BIN_WIDTH + 4*g +: 4]),
                .adjusted (adj_digits[4*g +: 4])
            );
        end
    endgenerate

    assign iter_result = {adj_digits, shifted[BIN_WIDTH-1:0]};
    assign last_iter   = (n_reg == N_W'(1));

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = bad_digit ? DONE : OP;
                end
            end
            OP: begin
                if (last_iter) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath and output next-values; every output is registered below.
    always_comb begin
        work_next  = work_reg;
        n_next     = n_reg;
        bin_next   = bin_out;
        err_next   = err;
        done_next  = 1'b0;
        ready_next = (state_next == IDLE);
        unique case (state_reg)
            IDLE: begin
                if (start) begin
                    if (bad_digit) begin
                        err_next  = 1'b1;
                        bin_next  = '0;
                        done_next = 1'b1;
                    end else begin
                        work_next = {bcd_packed, {BIN_WIDTH{1'b0}}};
                        n_next    = N_W'(BIN_WIDTH);
                        err_next  = 1'b0;
                    end
                end
            end
            OP: begin
                work_next = iter_result;
                n_next    = n_reg - N_W'(1);
                if (last_iter) begin
                    bin_next  = iter_result[BIN_WIDTH-1:0];
                    done_next = 1'b1;
                end
            end
            DONE: begin
                done_next = 1'b0;
            end
            default: begin
                done_next = 1'b0;
            end
        endcase
    end

    // Working register, iteration counter and output registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            work_reg  <= '0;
            n_reg     <= '0;
            bin_out   <= '0;
            err       <= 1'b0;
            done_tick <= 1'b0;
            ready     <= 1'b1;
        end else begin
            work_reg  <= work_next;
            n_reg     <= n_next;
            bin_out   <= bin_next;
            err       <= err_next;
            done_tick <= done_next;
            ready     <= ready_next;
        end
    end

endmodule

// File: tb/tb_bcd_to_bin.sv
// Self-checking bench for bcd_to_bin.
// Reference results come from plain decimal arithmetic.
module tb_bcd_to_bin;

    logic        clk;
    logic        reset;
    logic        start;
    logic [3:0]  bcd_in [4];
    logic        ready;
    logic        done_tick;
    logic        err;
    logic [13:0] bin_out;

    int tests;
    int fails;

    bcd_to_bin #(.DIGITS(4), .BIN_WIDTH(14)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .bcd_in    (bcd_in),
        .ready     (ready),
        .done_tick (done_tick),
        .err       (err),
        .bin_out   (bin_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive digits given MSD first, start, and count edges until done_tick.
    task automatic convert(input logic [3:0] d3, input logic [3:0] d2,
                           input logic [3:0] d1, input logic [3:0] d0,
                           input bit scramble,
                           output int lat, output bit ready_low);
        int k;
        k = 0;
        while (!ready && k < 40) begin
            step();
            k++;
        end
        bcd_in[3] = d3;
        bcd_in[2] = d2;
        bcd_in[1] = d1;
        bcd_in[0] = d0;
        start = 1'b1;
        step();
        start = 1'b0;
        lat = 1;
        ready_low = 1'b1;
        while (!done_tick && lat < 40) begin
            if (ready) ready_low = 1'b0;
            if (scramble) begin
                for (int i = 0; i < 4; i++) bcd_in[i] = 4'($urandom_range(0, 15));
            end
            step();
            lat++;
        end
        if (ready) ready_low = 1'b0;
    endtask

    initial begin
        int lat;
        bit rl;
        int v;
        int exp_bin;
        bit bad;
        logic [3:0] d [4];
        int pulses;
        int last_pulse;
        int gap_ok;
        int bin_ok;
        int seen_done;

        tests = 0;
        fails = 0;
        start = 1'b0;
        for (int i = 0; i < 4; i++) bcd_in[i] = 4'd0;
        reset = 1'b0;
        step();
        step();
        check("reset_ready", 32'(ready), 32'd1);
        check("reset_done", 32'(done_tick), 32'd0);
        check("reset_err", 32'(err), 32'd0);
        check("reset_bin", 32'(bin_out), 32'd0);
        reset = 1'b1;
        step();

        convert(4'd0, 4'd0, 4'd0, 4'd0, 1'b0, lat, rl);
        check("zero_lat", 32'(lat), 32'd15);
        check("zero_bin", 32'(bin_out), 32'd0);
        check("zero_err", 32'(err), 32'd0);
        step();
        check("zero_pulse_end", 32'(done_tick), 32'd0);
        check("zero_ready_back", 32'(ready), 32'd1);

        convert(4'd9, 4'd9, 4'd9, 4'd9, 1'b0, lat, rl);
        check("max_bin", 32'(bin_out), 32'd9999);
        check("max_lat", 32'(lat), 32'd15);
        check("max_ready_low", 32'(rl), 32'd1);

        convert(4'd1, 4'd2, 4'd3, 4'd4, 1'b0, lat, rl);
        check("b1234_bin", 32'(bin_out), 32'd1234);
        check("b1234_ready_low", 32'(rl), 32'd1);

        convert(4'd0, 4'd4, 4'hA, 4'd1, 1'b0, lat, rl);
        check("bad_lat", 32'(lat), 32'd1);
        check("bad_err", 32'(err), 32'd1);
        check("bad_bin", 32'(bin_out), 32'd0);

        convert(4'd0, 4'd0, 4'd4, 4'd2, 1'b0, lat, rl);
        check("after_bad_err", 32'(err), 32'd0);
        check("after_bad_bin", 32'(bin_out), 32'd42);

        // Start held high: one conversion every 16 cycles.
        step();
        bcd_in[3] = 4'd5;
        bcd_in[2] = 4'd0;
        bcd_in[1] = 4'd0;
        bcd_in[0] = 4'd0;
        start = 1'b1;
        pulses = 0;
        last_pulse = -1;
        gap_ok = 1;
        bin_ok = 1;
        for (int c = 1; c <= 50; c++) begin
            step();
            if (done_tick) begin
                if (last_pulse >= 0 && c - last_pulse != 16) gap_ok = 0;
                if (bin_out != 14'd5000) bin_ok = 0;
                last_pulse = c;
                pulses++;
            end
        end
        start = 1'b0;
        check("held_pulses", 32'(pulses), 32'd3);
        check("held_period", 32'(gap_ok), 32'd1);
        check("held_bin", 32'(bin_ok), 32'd1);

        // Reset during OP iteration 7 discards the conversion.
        while (!ready) step();
        bcd_in[3] = 4'd9;
        bcd_in[2] = 4'd9;
        bcd_in[1] = 4'd9;
        bcd_in[0] = 4'd9;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 0; c < 6; c++) step();
        reset = 1'b0;
        step();
        reset = 1'b1;
        check("midrst_ready", 32'(ready), 32'd1);
        check("midrst_bin", 32'(bin_out), 32'd0);
        check("midrst_done", 32'(done_tick), 32'd0);
        seen_done = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (done_tick) seen_done = 1;
        end
        check("midrst_no_done", 32'(seen_done), 32'd0);

        // Randomised sweep with input scrambling after accept.
        for (int t = 0; t < 300; t++) begin
            v = (t == 0) ? 9999 : (t == 1) ? 1 : int'($urandom_range(0, 9999));
            d[0] = 4'(v % 10);
            d[1] = 4'((v / 10) % 10);
            d[2] = 4'((v / 100) % 10);
            d[3] = 4'(v / 1000);
            bad = ($urandom_range(0, 7) == 0);
            if (bad) d[$urandom_range(0, 3)] = 4'($urandom_range(10, 15));
            exp_bin = bad ? 0 : v;
            convert(d[3], d[2], d[1], d[0], 1'b1, lat, rl);
            check("rnd_bin", 32'(bin_out), 32'(exp_bin));
            check("rnd_err", 32'(err), 32'(bad));
            check("rnd_lat", 32'(lat), bad ? 32'd1 : 32'd15);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
